multicycle_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle MIPS-subset datapath. Sequences each instruction

---
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle MIPS-subset datapath.
// Optional `MEM_HANDSHAKE_EN: FETCH/MEMRD/MEMWR wait for mem_ready.
module multicycle_ctrl #(
    parameter int OP_BITS    = 6,
    parameter int FUNCT_BITS = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_BITS-1:0] opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               ext_sel,
    output logic               illegal_op,
    output logic [3:0]         state
);

    localparam logic [3:0] S_RST    = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;

    localparam logic [OP_BITS-1:0] OP_R    = OP_BITS'(6'b000000);
    localparam logic [OP_BITS-1:0] OP_J    = OP_BITS'(6'b000010);
    localparam logic [OP_BITS-1:0] OP_BEQ  = OP_BITS'(6'b000100);
    localparam logic [OP_BITS-1:0] OP_ADDI = OP_BITS'(6'b001000);
    localparam logic [OP_BITS-1:0] OP_LW   = OP_BITS'(6'b100011);
    localparam logic [OP_BITS-1:0] OP_SW   = OP_BITS'(6'b101011);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       mem_ok;

    // funct is decoded by ALU control, not here
    logic [FUNCT_BITS-1:0] unused_funct;
    assign unused_funct = '0;

`ifdef MEM_HANDSHAKE_EN
    assign mem_ok = mem_ready;
`else
    logic unused_ready;
    assign unused_ready = mem_ready;
    assign mem_ok       = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_RST;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW,
                    OP_SW:   state_d = S_MEMADR;
                    OP_R:    state_d = S_EXEC;
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_RST;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        ext_sel    = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC and IR load only in the cycle memory delivers
                mem_read  = 1'b1;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
                alu_src_b = 2'b01;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = !(opcode inside
                    {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J});
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_write  = zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                ext_sel  = 1'b1;
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level model of multicycle_ctrl plus directed vectors.
// Honors `MEM_HANDSHAKE_EN the same way as the design.
module tb_multicycle_ctrl;

`ifdef MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    typedef struct packed {
        logic       pcw, irw, mrd, mwr, iod, rw, rd, m2r, asa;
        logic [1:0] asb, aop, psrc;
        logic       ext, ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, ir_write, mem_read, mem_write, i_or_d;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, ext_sel, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;
    ctl_t       got;

    int vectors = 0;
    int miscompares = 0;
    int mdl = 0;
    int q[$];
    int trace[$];
    int pcw_n, irw_n, rw_n, ext_n, ill_n, mwr_n;

    multicycle_ctrl #(.OP_BITS(6), .FUNCT_BITS(6)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .ext_sel(ext_sel), .illegal_op(illegal_op),
        .state(state)
    );

    assign got = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
                  ext_sel, illegal_op};

    always #5 clk = ~clk;

    // Model: each opcode maps to the list of states visited after FETCH
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl = 0;
            q.delete();
        end else if (!(HS && !mem_ready && (mdl == 1 || mdl == 4 || mdl == 6))) begin
            if (mdl == 1) begin
                case (opcode)
                    6'b100011: q = '{2, 3, 4, 5};
                    6'b101011: q = '{2, 3, 6};
                    6'b000000: q = '{2, 7, 8};
                    6'b000100: q = '{2, 9};
                    6'b001000: q = '{2, 10, 11};
                    6'b000010: q = '{2, 12};
                    default:   q = '{2};
                endcase
            end
            if (q.size() > 0) mdl = q.pop_front();
            else mdl = 1;
        end
    end

    function automatic ctl_t exp_ctl(int s, logic z, logic mr, logic [5:0] op);
        ctl_t c = '0;
        case (s)
            1: begin
                c.pcw = HS ? mr : 1'b1;
                c.irw = HS ? mr : 1'b1;
                c.mrd = 1'b1;
                c.asb = 2'b01;
            end
            2: begin
                c.asb = 2'b11;
                c.ill = !(op inside {6'b100011, 6'b101011, 6'b000000,
                                     6'b000100, 6'b001000, 6'b000010});
            end
            3:  begin c.asa = 1'b1; c.asb = 2'b10; end
            4:  begin c.iod = 1'b1; c.mrd = 1'b1; end
            5:  begin c.rw = 1'b1; c.m2r = 1'b1; end
            6:  begin c.iod = 1'b1; c.mwr = 1'b1; end
            7:  begin c.asa = 1'b1; c.aop = 2'b10; end
            8:  begin c.rw = 1'b1; c.rd = 1'b1; end
            9:  begin c.asa = 1'b1; c.aop = 2'b01; c.psrc = 2'b01; c.pcw = z; end
            10: begin c.asa = 1'b1; c.asb = 2'b10; end
            11: c.rw = 1'b1;
            12: begin c.ext = 1'b1; c.psrc = 2'b10; c.pcw = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    always @(negedge clk) begin : cmp
        ctl_t e;
        e = exp_ctl(mdl, zero, mem_ready, opcode);
        vectors++;
        if (state !== 4'(mdl) || got !== e) begin
            miscompares++;
            $display("FAIL cycle @%0t: state %0d ctl %h, want state %0d ctl %h",
                     $time, state, got, mdl, e);
        end
    end

    task automatic check(string name, int g, int w);
        vectors++;
        if (g != w) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, g, w);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_instr(input logic [5:0] op, input logic z,
                            input int fstall, input bit rnd);
        int  stall = fstall;
        bit  found = 0;
        bit  left = 0;
        bit  done = 0;
        trace.delete();
        pcw_n = 0; irw_n = 0; rw_n = 0; ext_n = 0; ill_n = 0; mwr_n = 0;
        for (int i = 0; i < 60; i++) begin
            if (state == 4'd1) begin
                found = 1;
                break;
            end
            tick();
        end
        if (!found) begin
            check("wait FETCH timeout", 0, 1);
            return;
        end
        opcode = op;
        zero   = z;
        for (int n = 0; n < 80; n++) begin
            mem_ready = (stall > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (stall > 0) stall--;
            #1;
            trace.push_back(int'(state));
            if (state != 4'd1) left = 1;
            else if (left) begin
                done = 1;
                break;
            end
            pcw_n += int'(pc_write);
            irw_n += int'(ir_write);
            rw_n  += int'(reg_write);
            ext_n += int'(ext_sel);
            ill_n += int'(illegal_op);
            mwr_n += int'(mem_write);
            tick();
        end
        if (!done) check("instr timeout", 0, 1);
    endtask

    task automatic check_trace(string name, int exp[$]);
        int idx = -1;
        for (int i = 0; i < exp.size(); i++) begin
            if (idx < 0 && (i >= trace.size() || trace[i] != exp[i])) idx = i;
        end
        if (idx < 0 && trace.size() != exp.size()) idx = exp.size();
        if (idx < 0) check({name, " trace"}, 0, 0);
        else if (idx >= exp.size()) check({name, " trace len"}, trace.size(), exp.size());
        else if (idx >= trace.size()) check({name, " trace len"}, trace.size(), exp.size());
        else check($sformatf("%s trace[%0d]", name, idx), trace[idx], exp[idx]);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int exp[$];
        logic [5:0] ops[7];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b000010, 6'b111111};
        #3;
        check("reset state", int'(state), 0);
        check("reset outputs", int'(got), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post-reset FETCH", int'(state), 1);

        do_instr(6'b100011, 1'b0, 0, 1'b0);
        exp = '{1, 2, 3, 4, 5, 1};   check_trace("lw", exp);
        check("lw reg_write cycles", rw_n, 1);

        do_instr(6'b101011, 1'b0, 0, 1'b0);
        exp = '{1, 2, 3, 6, 1};      check_trace("sw", exp);
        check("sw mem_write cycles", mwr_n, 1);

        do_instr(6'b000000, 1'b0, 0, 1'b0);
        exp = '{1, 2, 7, 8, 1};      check_trace("R", exp);

        do_instr(6'b001000, 1'b0, 0, 1'b0);
        exp = '{1, 2, 10, 11, 1};    check_trace("addi", exp);

        do_instr(6'b000100, 1'b1, 0, 1'b0);
        exp = '{1, 2, 9, 1};         check_trace("beq z1", exp);
        check("beq z1 pc_write cycles", pcw_n, 2);

        do_instr(6'b000100, 1'b0, 0, 1'b0);
        check_trace("beq z0", exp);
        check("beq z0 pc_write cycles", pcw_n, 1);

        do_instr(6'b000010, 1'b0, 0, 1'b0);
        exp = '{1, 2, 12, 1};        check_trace("j", exp);
        check("j ext_sel cycles", ext_n, 1);

        do_instr(6'b111111, 1'b0, 0, 1'b0);
        exp = '{1, 2, 1};            check_trace("illegal", exp);
        check("illegal_op cycles", ill_n, 1);
        check("illegal reg_write cycles", rw_n + mwr_n, 0);

        if (HS) begin
            do_instr(6'b000000, 1'b0, 3, 1'b0);
            exp = '{1, 1, 1, 1, 2, 7, 8, 1};
            check_trace("stall fetch", exp);
            check("stall pc_write cycles", pcw_n, 1);
            check("stall ir_write cycles", irw_n, 1);
        end

        for (int k = 0; k < 40; k++) begin
            do_instr(ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)), 0, 1'b1);
        end

        do_instr(6'b100011, 1'b0, 0, 1'b0);
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 20 && state != 4'd4; i++) tick();
        check("reach MEMRD", int'(state), 4);
        rst_n = 1'b0;
        #1;
        check("async reset state", int'(state), 0);
        check("async reset outputs", int'(got), 0);
        tick();
        tick();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release FETCH", int'(state), 1);
        tick();
        do_instr(6'b100011, 1'b0, 0, 1'b0);
        exp = '{1, 2, 3, 4, 5, 1};   check_trace("lw after reset", exp);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
